// File: rtl/pe_pkg.sv
// Shared definitions for the PE MAC array downstream stages: default sizes,
// saturation limits and the drain state encoding.
package pe_pkg;
    localparam int PE_DATA_WIDTH = 32;
    localparam int PE_ARRAY_ROWS = 8;

    localparam logic [PE_DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(PE_DATA_WIDTH-1){1'b1}}};
    localparam logic [PE_DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(PE_DATA_WIDTH-1){1'b0}}};

    typedef enum logic {
        EMPTY = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;
endpackage

// File: rtl/sat_add32.sv
// Combinational signed saturating adder; the sum is formed one bit wider and
// clamped to the most positive / most negative representable value.
module sat_add32
    import pe_pkg::*;
#(
    parameter int W = PE_DATA_WIDTH
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         sat
);
    localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

    logic [W:0] wide;

    always_comb begin
        wide = {a[W-1], a} + {b[W-1], b};
        sat  = wide[W] ^ wide[W-1];
        sum  = wide[W-1:0];
        if (sat) begin
            sum = wide[W] ? MIN_V : MAX_V;
        end
    end
endmodule

// File: rtl/mac_acc_drain.sv
// Accumulates per-row MAC results across K tiles and drains each completed
// tile from a second buffer onto a word-wide valid/ready stream.
module mac_acc_drain
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = PE_DATA_WIDTH,
    parameter int ARRAY_ROWS = PE_ARRAY_ROWS,
    parameter int ROW_W      = (ARRAY_ROWS > 1) ? $clog2(ARRAY_ROWS) : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear_i,
    input  logic                             mac_en_i,
    input  logic                             last_i,
    input  logic [DATA_WIDTH*ARRAY_ROWS-1:0] mac_result_i,
    output logic                             stall_o,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [DATA_WIDTH-1:0]            out_data_o,
    output logic [ROW_W-1:0]                 out_row_o,
    output logic                             out_last_o,
    output logic                             sat_o,
    output logic                             proto_err_o
);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ARRAY_ROWS - 1);

    logic                  en_d_reg;
    logic                  last_d_reg;
    logic [DATA_WIDTH-1:0] acc_reg   [ARRAY_ROWS];
    logic [DATA_WIDTH-1:0] drain_reg [ARRAY_ROWS];
    logic [ROW_W-1:0]      row_reg;
    drain_state_t          state_reg;
    logic                  sat_reg;
    logic                  proto_reg;

    logic [DATA_WIDTH-1:0] sum_next [ARRAY_ROWS];
    logic [ARRAY_ROWS-1:0] sat_vec;
    logic                  drain_full;
    logic                  last_row;
    logic                  load;

    genvar gi;
    generate
        for (gi = 0; gi < ARRAY_ROWS; gi++) begin : g_row
            sat_add32 #(.W(DATA_WIDTH)) u_add (
                .a   (acc_reg[gi]),
                .b   (mac_result_i[gi*DATA_WIDTH +: DATA_WIDTH]),
                .sum (sum_next[gi]),
                .sat (sat_vec[gi])
            );
        end
    endgenerate

    assign drain_full = (state_reg == DRAIN);
    assign last_row   = (row_reg == LAST_ROW);
    // A final tile only moves into the drain buffer when the buffer is free at
    // the start of the cycle, even if the last word is handshaking right now.
    assign load       = en_d_reg & last_d_reg & ~drain_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_d_reg   <= 1'b0;
            last_d_reg <= 1'b0;
            row_reg    <= '0;
            state_reg  <= EMPTY;
            sat_reg    <= 1'b0;
            proto_reg  <= 1'b0;
            for (int i = 0; i < ARRAY_ROWS; i++) begin
                acc_reg[i]   <= '0;
                drain_reg[i] <= '0;
            end
        end else if (clear_i) begin
            en_d_reg   <= 1'b0;
            last_d_reg <= 1'b0;
            row_reg    <= '0;
            state_reg  <= EMPTY;
            sat_reg    <= 1'b0;
            proto_reg  <= 1'b0;
            for (int i = 0; i < ARRAY_ROWS; i++) begin
                acc_reg[i]   <= '0;
                drain_reg[i] <= '0;
            end
        end else begin
            en_d_reg   <= mac_en_i;
            last_d_reg <= mac_en_i & last_i;

            if (en_d_reg) begin
                for (int i = 0; i < ARRAY_ROWS; i++) begin
                    acc_reg[i] <= load ? '0 : sum_next[i];
                    if (load) begin
                        drain_reg[i] <= sum_next[i];
                    end
                end
                if (|sat_vec) begin
                    sat_reg <= 1'b1;
                end
                if (last_d_reg && drain_full) begin
                    proto_reg <= 1'b1;
                end
            end

            case (state_reg)
                EMPTY: begin
                    if (load) begin
                        state_reg <= DRAIN;
                        row_reg   <= '0;
                    end
                end
                DRAIN: begin
                    if (out_ready_i) begin
                        if (last_row) begin
                            row_reg   <= '0;
                            state_reg <= EMPTY;
                        end else begin
                            row_reg <= row_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= EMPTY;
            endcase
        end
    end

    assign stall_o     = drain_full | last_d_reg;
    assign out_valid_o = drain_full;
    assign out_data_o  = drain_full ? drain_reg[row_reg] : '0;
    assign out_row_o   = drain_full ? row_reg : '0;
    assign out_last_o  = drain_full & last_row;
    assign sat_o       = sat_reg;
    assign proto_err_o = proto_reg;
endmodule
